// File: rtl/ram_pkg.sv
// Shared definitions for the RAM access controller: default geometry and FSM states.
package ram_pkg;

    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int DEPTH_DEF      = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_CAPTURE,
        ST_RESP
    } state_t;

endpackage

// File: rtl/single_port_ram.sv
// Asynchronous-style single-port RAM model: writes and read latching happen on the falling edge,
// read data is driven onto the shared bus while cs & oe & !we. 'corrupt' XORs into stored data.
module single_port_ram #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  oe,
    input  logic [DATA_WIDTH-1:0] corrupt,
    inout  wire  [DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  drive;

    assign drive = cs && oe && !we;

    always_ff @(negedge clk) begin
        if (cs && we) begin
            mem[addr] <= data ^ corrupt;
        end
        if (drive) begin
            rd_q <= mem[addr];
        end
    end

    assign data = drive ? rd_q : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/ram_access_ctrl.sv
// Request/response front end for an external single-port RAM with a shared tri-state data bus.
// Optional write readback verification is enabled with macro RAM_ACCESS_CTRL_VERIFY_EN.
module ram_access_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

    // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

    state_t                state;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  out_of_range;
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
    logic                  we_q;
`endif

    assign out_of_range = {1'b0, req_addr} >= DEPTH_LIM;

    // The bus is only ever driven by us while ram_we is high, so it never fights a RAM read.
    assign ram_data = ram_we ? wdata_q : {DATA_WIDTH{1'bz}};

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req_valid) begin
            wdata_q <= req_wdata;
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
            we_q    <= req_we;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_oe    <= 1'b0;
            ram_addr  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        rsp_rdata <= '0;
                        ram_addr  <= req_addr;
                        if (out_of_range) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else if (req_we) begin
                            state  <= ST_WRITE;
                            ram_cs <= 1'b1;
                            ram_we <= 1'b1;
                        end else begin
                            state  <= ST_READ;
                            ram_cs <= 1'b1;
                            ram_oe <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
                    state  <= ST_READ;
                    ram_we <= 1'b0;
                    ram_oe <= 1'b1;
`else
                    state     <= ST_RESP;
                    ram_cs    <= 1'b0;
                    ram_we    <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
`endif
                end
                ST_READ: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    state     <= ST_RESP;
                    ram_cs    <= 1'b0;
                    ram_oe    <= 1'b0;
                    rsp_valid <= 1'b1;
`ifdef RAM_ACCESS_CTRL_VERIFY_EN
                    // A verify readback reports only the comparison result, never the data.
                    if (we_q) begin
                        rsp_rdata <= '0;
                        rsp_err   <= (ram_data != wdata_q);
                    end else begin
                        rsp_rdata <= ram_data;
                        rsp_err   <= 1'b0;
                    end
`else
                    rsp_rdata <= ram_data;
                    rsp_err   <= 1'b0;
`endif
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ram_access_ctrl.md
RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: RAM data width.
REQ-003 SHALL have parameter DEPTH, default 4: number of implemented RAM words.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on posedge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port req_valid, input, 1: client request present.
REQ-007 SHALL have port req_ready, output, 1: controller can accept a request.
REQ-008 SHALL have port req_we, input, 1: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, ADDR_WIDTH: target word.
REQ-010 SHALL have port req_wdata, input, DATA_WIDTH: write data.
REQ-011 SHALL have port rsp_valid, output, 1: response present.
REQ-012 SHALL have port rsp_ready, input, 1: client accepts response.
REQ-013 SHALL have port rsp_rdata, output, DATA_WIDTH: read data; 0 for writes and errors.
REQ-014 SHALL have port rsp_err, output, 1: out-of-range address, or readback mismatch when enabled.
REQ-015 SHALL have ports ram_addr (ADDR_WIDTH), ram_cs, ram_we, ram_oe, all outputs: RAM control.
REQ-016 SHALL have port ram_data, inout, DATA_WIDTH: shared bus; driven only during write cycles, otherwise 'z.

Function
REQ-017 SHALL implement FSM IDLE, WRITE, READ, CAPTURE, RESP; all RAM outputs registered.
REQ-018 SHALL assert req_ready only in IDLE; a request is accepted on a posedge with req_valid & req_ready.
REQ-019 SHALL latch req_we, req_addr and req_wdata on acceptance; later changes to the inputs are ignored.
REQ-020 SHALL check on acceptance whether req_addr >= DEPTH; if so, go to RESP with rsp_err=1 and no RAM access (cs stays 0).
REQ-021 SHALL, for an in-range write, go IDLE->WRITE and drive cs=1, we=1, oe=0, ram_data=wdata for exactly one cycle, then go to RESP.
REQ-022 SHALL, for an in-range read, go IDLE->READ and drive cs=1, we=0, oe=1 for one cycle (RAM latches on the negedge).
REQ-023 SHALL, in CAPTURE, keep cs=1 and oe=1, sample ram_data into rsp_rdata on that posedge, then go to RESP.
REQ-024 SHALL hold rsp_valid=1 in RESP with stable rsp_rdata/rsp_err until rsp_ready=1, then return to IDLE.
REQ-025 SHALL give an acceptance-to-rsp_valid latency of 2 cycles for writes, 3 for reads, and 1 for errors.
REQ-026 SHALL never drive ram_data while ram_we=0, so there is no bus contention with RAM read drive.
REQ-027 SHALL, if rsp_ready is already high when RESP is entered, complete in that cycle, which allows back-to-back requests every (latency+1) cycles.
REQ-028 SHALL treat addr = DEPTH-1 as valid and addr = DEPTH as error; addresses do not wrap.

Reset
REQ-029 SHALL, with rst=1 at posedge, enter IDLE and set req_ready=1 (effective the following cycle), rsp_valid=0, rsp_rdata=0, rsp_err=0, ram_cs=0, ram_we=0, ram_oe=0, ram_addr=0, with ram_data released to 'z.
REQ-030 SHALL abort any in-flight transaction on reset mid-operation with no response issued; a write is not retried.

Configuration
REQ-031 SHALL support macro RAM_ACCESS_CTRL_VERIFY_EN; when defined, each write is followed by an internal read (READ/CAPTURE) of the same address, and rsp_err=1 if the readback differs from wdata, giving a write latency of 4.
REQ-032 SHALL, when the macro is undefined, omit the verify path and its comparator entirely; writes follow REQ-021.

Structure
REQ-033 SHALL place the FSM state enum and the default ADDR_WIDTH/DATA_WIDTH/DEPTH constants in shared package ram_pkg.
REQ-034 SHALL be a single module with no sub-modules; the bench instantiates it with single_port_ram on ram_*.

Verification
REQ-035 SHALL cover: reset, then write addr 2 data 16'hA5A5 -> ram cs/we high for 1 cycle, rsp_valid after 2 cycles, rsp_err=0.
REQ-036 SHALL cover: read addr 2 after that write -> rsp_rdata=16'hA5A5 after 3 cycles, with ram_data never driven by the controller.
REQ-037 SHALL cover: request addr 4 with DEPTH=4 -> rsp_err=1 after 1 cycle, ram_cs stays 0; addr 3 accepted normally.
REQ-038 SHALL cover: rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0 throughout.
REQ-039 SHALL cover: rst asserted during READ -> next cycle IDLE, all outputs at reset values, no rsp_valid.
REQ-040 SHALL cover: with VERIFY_EN, write 16'h1234 with the bench forcing a RAM corruption -> rsp_err=1 at latency 4.
